legv8_multicycle_sequencer: RTL and testbench
=============================================

# legv8_multicycle_sequencer

Multi-cycle control sequencer for the LEGv8 datapath. It steps each instruction through fetch, decode, execute, memory and writeback over several clock cycles, sharing one memory port between instruction fetch and data access. It drives the datapath's per-cycle control strobes from an 11-bit opcode latched into the instruction register. It also flags unsupported opcodes.

## Interface
Parameters:
- PC_STEP, 4, byte increment applied to PC on fetch completion (passed to datapath via pcSrc select only; documented for test).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  11  instruction[31:21] from instruction register (valid from DECODE on)
- aluZero  in  1  ALU zero flag, valid in EXEC
- memReady  in  1  shared memory completes current access this cycle
- memReq  out  1  memory access request
- memWriteEn  out  1  access is a write (STUR)
- iorD  out  1  0 = PC addresses memory, 1 = ALU result
- irWrite  out  1  load instruction register
- pcWrite  out  1  update PC
- pcSrc  out  2  0 = PC+PC_STEP, 1 = PC+branch offset, 2 = PC+B offset
- reg2Loc  out  1  read-port-2 field select (1 = Rt, for STUR/CBZ)
- aluSrc  out  1  0 = register, 1 = sign-extended immediate
- aluOp  out  2  00 add, 01 pass B, 10 R-type funct
- memToReg  out  1  writeback source is memory data
- regWrite  out  1  register file write enable
- fault  out  1  sticky illegal-opcode flag

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, FAULT. Outputs are Moore-decoded from the state register, except that irWrite, pcWrite and the FETCH→DECODE step are qualified by memReady, and pcWrite in EXEC is qualified by aluZero.
- Opcode classes:
  - R-type: ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550.
  - LDUR: 0x7C2.
  - STUR: 0x7C0.
  - CBZ: opcode[10:3] = 0xB4.
  - B: opcode[10:5] = 0x05.
  - Anything else is illegal.
- RESET → FETCH unconditionally on the first clock after rst_n deasserts.
- FETCH: memReq=1, iorD=0. Hold while memReady=0. On memReady=1: irWrite=1, pcWrite=1, pcSrc=0, then go to DECODE.
- DECODE:
  - B: pcWrite=1, pcSrc=2, then FETCH.
  - Illegal: go to FAULT.
  - All others: go to EXEC.
  - reg2Loc=1 for STUR and CBZ.
- EXEC:
  - LDUR/STUR: aluSrc=1, aluOp=00, then MEM.
  - R-type: aluOp=10, then WB.
  - CBZ: aluOp=01, reg2Loc=1, pcWrite=aluZero, pcSrc=1, then FETCH.
- MEM: memReq=1, iorD=1, memWriteEn=1 for STUR. Hold until memReady. Then LDUR → WB, STUR → FETCH.
- WB: regWrite=1 for one cycle; memToReg=1 for LDUR. Then FETCH.
- FAULT: all strobes 0, fault=1. Only reset exits.
- memReq stays asserted continuously while waiting. memWriteEn and iorD stay stable across the whole wait.

## Timing
- Reset values: state RESET; every output 0, including fault and the perf counter.
- Minimum cycles per instruction (memReady=1 on first request):
  - B: 2
  - CBZ: 3
  - R-type: 4
  - STUR: 4
  - LDUR: 5
- Each memReady=0 cycle in FETCH or MEM adds one cycle.
- pcWrite and regWrite are single-cycle pulses per instruction. irWrite fires exactly once per fetch.
- An opcode change while not in DECODE/EXEC/MEM/WB is ignored, because opcode is only sampled in those states.
- If rst_n asserts mid-access, memReq drops asynchronously and no strobe fires.
- memReady asserted outside FETCH/MEM is ignored.

## Configuration
- LEGV8_SEQ_PERF_EN defined: adds output `retired` (out, 32 bits), a counter that increments on each transition into FETCH from DECODE, EXEC, MEM or WB. It wraps 0xFFFFFFFF→0 and resets to 0.
- Not defined: the port and the counter are absent, and the sequencer is otherwise identical.

## Structure
- Shared package `legv8_pkg`:
  - state enum
  - opcode constants (R-type, LDUR, STUR, CBZ/B prefixes)
  - aluOp encodings
  - pcSrc encodings
- Sub-module `legv8_opcode_class`: combinational opcode → class (R, LOAD, STORE, CBZ, B, ILLEGAL) decoder, reused by the later pipelined control.

## Test plan
- Reset released, memReady=1, opcode 0x458 → states FETCH, DECODE, EXEC, WB; regWrite pulses in cycle 4, aluOp=10 in EXEC.
- LDUR 0x7C2 with memReady low for 2 cycles in MEM → memReq/iorD held 3 cycles, memToReg=1 and regWrite=1 in WB, total 7 cycles.
- CBZ (opcode 0x5A0) with aluZero=1 → pcWrite=1, pcSrc=1 in EXEC. With aluZero=0 → pcWrite=0, back to FETCH.
- B (opcode 0x0A0) → pcWrite=1, pcSrc=2 in DECODE, next FETCH at cycle 3.
- Opcode 0x000 → fault=1 from the cycle after DECODE, all strobes 0 for 10 further cycles; rst_n pulse clears fault.
- rst_n asserted during FETCH wait with memReq=1 → memReq=0 immediately; with LEGV8_SEQ_PERF_EN, `retired` reads 0 after reset and 3 after ADD, STUR, B.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_pkg
//  Description : Shared constants and types for the LEGv8 control logic:
//                sequencer state codes, opcode constants, opcode classes,
//                aluOp and pcSrc encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  // Sequencer state codes
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // Full 11-bit opcodes
  localparam logic [10:0] C_OPC_ADD  = 11'h458;
  localparam logic [10:0] C_OPC_SUB  = 11'h658;
  localparam logic [10:0] C_OPC_AND  = 11'h450;
  localparam logic [10:0] C_OPC_ORR  = 11'h550;
  localparam logic [10:0] C_OPC_LDUR = 11'h7C2;
  localparam logic [10:0] C_OPC_STUR = 11'h7C0;

  // Prefix-matched opcodes: CBZ on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0] C_PFX_CBZ = 8'hB4;
  localparam logic [5:0] C_PFX_B   = 6'h05;

  // ALU operation select
  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_PASSB = 2'b01;
  localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;

  // PC source select
  localparam logic [1:0] C_PCSRC_SEQ = 2'd0;
  localparam logic [1:0] C_PCSRC_CB  = 2'd1;
  localparam logic [1:0] C_PCSRC_B   = 2'd2;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    CLASS_R       = 3'd0,
    CLASS_LOAD    = 3'd1,
    CLASS_STORE   = 3'd2,
    CLASS_CBZ     = 3'd3,
    CLASS_B       = 3'd4,
    CLASS_ILLEGAL = 3'd5
  } op_class_e;

endpackage : legv8_pkg
`default_nettype wire

// File: rtl/legv8_opcode_class.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_opcode_class
//  Description : Combinational LEGv8 opcode -> instruction class decoder.
//                Shared between the multi-cycle and pipelined control.
//  Revision    : 1.0 - initial release
// ============================================================================
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_e   op_class_o
);

  // Exact matches first, then prefix matches; anything else is illegal
  always_comb begin
    op_class_o = CLASS_ILLEGAL;
    if ((opcode_i == C_OPC_ADD) || (opcode_i == C_OPC_SUB) ||
        (opcode_i == C_OPC_AND) || (opcode_i == C_OPC_ORR)) begin
      op_class_o = CLASS_R;
    end else if (opcode_i == C_OPC_LDUR) begin
      op_class_o = CLASS_LOAD;
    end else if (opcode_i == C_OPC_STUR) begin
      op_class_o = CLASS_STORE;
    end else if (opcode_i[10:3] == C_PFX_CBZ) begin
      op_class_o = CLASS_CBZ;
    end else if (opcode_i[10:5] == C_PFX_B) begin
      op_class_o = CLASS_B;
    end
  end

endmodule : legv8_opcode_class
`default_nettype wire

// File: rtl/legv8_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_multicycle_sequencer
//  Description : Multi-cycle LEGv8 control sequencer. Steps each instruction
//                through FETCH/DECODE/EXEC/MEM/WB over one shared memory
//                port and flags illegal opcodes with a sticky fault.
//                Optional retired-instruction counter: LEGV8_SEQ_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module legv8_multicycle_sequencer
  import legv8_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        aluZero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWriteEn,
  output logic        iorD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        reg2Loc,
  output logic        aluSrc,
  output logic [1:0]  aluOp,
  output logic        memToReg,
  output logic        regWrite,
  output logic        fault
`ifdef LEGV8_SEQ_PERF_EN
  ,
  output logic [31:0] retired
`endif
);

  // PC_STEP only selects the datapath adder constant; reject nonsense values
  if (PC_STEP <= 0) begin : g_pc_step_check
    $error("PC_STEP must be positive");
  end

  logic [2:0] state_q;
  logic [2:0] state_d;
  op_class_e  op_class;

  legv8_opcode_class u_opcode_class (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  // Next-state and strobe decode; strobes default low in every state
  always_comb begin
    state_d    = state_q;
    memReq     = 1'b0;
    memWriteEn = 1'b0;
    iorD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = C_PCSRC_SEQ;
    reg2Loc    = 1'b0;
    aluSrc     = 1'b0;
    aluOp      = C_ALUOP_ADD;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_class)
          CLASS_B: begin
            pcWrite = 1'b1;
            pcSrc   = C_PCSRC_B;
            state_d = S_FETCH;
          end
          CLASS_ILLEGAL: begin
            state_d = S_FAULT;
          end
          CLASS_STORE, CLASS_CBZ: begin
            reg2Loc = 1'b1;
            state_d = S_EXEC;
          end
          default: begin
            state_d = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        case (op_class)
          CLASS_LOAD, CLASS_STORE: begin
            aluSrc  = 1'b1;
            aluOp   = C_ALUOP_ADD;
            state_d = S_MEM;
          end
          CLASS_R: begin
            aluOp   = C_ALUOP_RTYPE;
            state_d = S_WB;
          end
          CLASS_CBZ: begin
            aluOp   = C_ALUOP_PASSB;
            reg2Loc = 1'b1;
            pcWrite = aluZero;
            pcSrc   = C_PCSRC_CB;
            state_d = S_FETCH;
          end
          // The IR is stable from DECODE on, so no other class reaches here
          default: begin
            state_d = S_FAULT;
          end
        endcase
      end
      S_MEM: begin
        memReq     = 1'b1;
        iorD       = 1'b1;
        memWriteEn = (op_class == CLASS_STORE);
        if (memReady) begin
          state_d = (op_class == CLASS_LOAD) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (op_class == CLASS_LOAD);
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State register; async reset forces RESET so every strobe drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef LEGV8_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic        retire_evt;

  assign retire_evt = (state_d == S_FETCH) &&
                      ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)    || (state_q == S_WB));

  // Count completed instructions; wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else if (retire_evt) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule : legv8_multicycle_sequencer
`default_nettype wire

// File: tb/tb_legv8_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_legv8_multicycle_sequencer
//  Description : Directed, table-driven bench for the multi-cycle sequencer.
//                Optional checks of the retired counter: LEGV8_SEQ_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_legv8_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        aluZero;
  logic        memReady;
  logic        memReq, memWriteEn, iorD, irWrite, pcWrite;
  logic [1:0]  pcSrc;
  logic        reg2Loc, aluSrc;
  logic [1:0]  aluOp;
  logic        memToReg, regWrite, fault;
`ifdef LEGV8_SEQ_PERF_EN
  logic [31:0] retired;
`endif

  legv8_multicycle_sequencer #(.PC_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .aluZero    (aluZero),
    .memReady   (memReady),
    .memReq     (memReq),
    .memWriteEn (memWriteEn),
    .iorD       (iorD),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .reg2Loc    (reg2Loc),
    .aluSrc     (aluSrc),
    .aluOp      (aluOp),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .fault      (fault)
`ifdef LEGV8_SEQ_PERF_EN
    ,
    .retired    (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: memReq memWriteEn iorD irWrite pcWrite pcSrc[1:0]
  //                reg2Loc aluSrc aluOp[1:0] memToReg regWrite fault
  logic [13:0] outs;
  assign outs = {memReq, memWriteEn, iorD, irWrite, pcWrite, pcSrc,
                 reg2Loc, aluSrc, aluOp, memToReg, regWrite, fault};

  localparam logic [13:0] P_IDLE   = 14'd0;
  localparam logic [13:0] P_F_OK   = {1'b1,1'b0,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_F_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_D_R2L  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_D_B    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_E_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_E_MEM  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_E_CBZ1 = {1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_E_CBZ0 = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_M_LD   = {1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_M_ST   = {1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
  localparam logic [13:0] P_WB_R   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b1,1'b0};
  localparam logic [13:0] P_WB_LD  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0};
  localparam logic [13:0] P_FLT    = 14'd1;

  typedef struct {
    logic [10:0] op;
    logic        rdy;
    logic        z;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t v(logic [10:0] op, logic rdy, logic z, logic [13:0] e);
    vec_t r;
    r.op = op; r.rdy = rdy; r.z = z; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int n_pcw, n_irw, n_rw, n_mwe;
    logic [10:0] perf_ops[11];

    rst_n = 1'b0; opcode = 11'h000; aluZero = 1'b0; memReady = 1'b0;

    // One row per clock cycle, starting with the RESET cycle after release
    tbl.push_back(v(11'h000, 1'b1, 1'b0, P_IDLE));   // RESET ignores memReady
    tbl.push_back(v(11'h458, 1'b1, 1'b0, P_F_OK));   // ADD
    tbl.push_back(v(11'h458, 1'b1, 1'b0, P_IDLE));
    tbl.push_back(v(11'h458, 1'b1, 1'b0, P_E_R));
    tbl.push_back(v(11'h458, 1'b1, 1'b0, P_WB_R));
    tbl.push_back(v(11'h658, 1'b0, 1'b0, P_F_WAIT)); // SUB, one fetch stall
    tbl.push_back(v(11'h658, 1'b1, 1'b0, P_F_OK));
    tbl.push_back(v(11'h658, 1'b1, 1'b0, P_IDLE));
    tbl.push_back(v(11'h658, 1'b1, 1'b0, P_E_R));
    tbl.push_back(v(11'h658, 1'b1, 1'b0, P_WB_R));
    tbl.push_back(v(11'h7C2, 1'b1, 1'b0, P_F_OK));   // LDUR, two MEM stalls
    tbl.push_back(v(11'h7C2, 1'b1, 1'b0, P_IDLE));
    tbl.push_back(v(11'h7C2, 1'b1, 1'b0, P_E_MEM));
    tbl.push_back(v(11'h7C2, 1'b0, 1'b0, P_M_LD));
    tbl.push_back(v(11'h7C2, 1'b0, 1'b0, P_M_LD));
    tbl.push_back(v(11'h7C2, 1'b1, 1'b0, P_M_LD));
    tbl.push_back(v(11'h7C2, 1'b1, 1'b0, P_WB_LD));
    tbl.push_back(v(11'h7C0, 1'b1, 1'b0, P_F_OK));   // STUR
    tbl.push_back(v(11'h7C0, 1'b1, 1'b0, P_D_R2L));
    tbl.push_back(v(11'h7C0, 1'b1, 1'b0, P_E_MEM));
    tbl.push_back(v(11'h7C0, 1'b1, 1'b0, P_M_ST));
    tbl.push_back(v(11'h5A0, 1'b1, 1'b1, P_F_OK));   // CBZ taken
    tbl.push_back(v(11'h5A0, 1'b1, 1'b1, P_D_R2L));
    tbl.push_back(v(11'h5A0, 1'b1, 1'b1, P_E_CBZ1));
    tbl.push_back(v(11'h5A7, 1'b1, 1'b0, P_F_OK));   // CBZ not taken
    tbl.push_back(v(11'h5A7, 1'b1, 1'b0, P_D_R2L));
    tbl.push_back(v(11'h5A7, 1'b1, 1'b0, P_E_CBZ0));
    tbl.push_back(v(11'h0A0, 1'b1, 1'b0, P_F_OK));   // B
    tbl.push_back(v(11'h0A0, 1'b1, 1'b0, P_D_B));
    tbl.push_back(v(11'h450, 1'b1, 1'b0, P_F_OK));   // AND
    tbl.push_back(v(11'h450, 1'b1, 1'b0, P_IDLE));
    tbl.push_back(v(11'h450, 1'b1, 1'b0, P_E_R));
    tbl.push_back(v(11'h450, 1'b1, 1'b0, P_WB_R));
    tbl.push_back(v(11'h550, 1'b1, 1'b0, P_F_OK));   // ORR
    tbl.push_back(v(11'h550, 1'b1, 1'b0, P_IDLE));
    tbl.push_back(v(11'h550, 1'b1, 1'b0, P_E_R));
    tbl.push_back(v(11'h550, 1'b1, 1'b0, P_WB_R));
    tbl.push_back(v(11'h0BF, 1'b1, 1'b0, P_F_OK));   // B, top of prefix range
    tbl.push_back(v(11'h0BF, 1'b1, 1'b0, P_D_B));
    tbl.push_back(v(11'h000, 1'b1, 1'b0, P_F_OK));   // illegal opcode
    tbl.push_back(v(11'h000, 1'b1, 1'b0, P_IDLE));
    for (int k = 0; k < 11; k++) begin
      tbl.push_back(v(11'h458, 1'b1, 1'b1, P_FLT));  // sticky, legal opcode ignored
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {18'd0, outs}, {18'd0, P_IDLE});
`ifdef LEGV8_SEQ_PERF_EN
    check("reset_retired", retired, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op; memReady = tbl[i].rdy; aluZero = tbl[i].z;
      @(negedge clk);
      check($sformatf("row%0d", i), {18'd0, outs}, {18'd0, tbl[i].exp});
      @(posedge clk);
      #1;
    end

    // Asynchronous reset clears the sticky fault without a clock edge
    rst_n = 1'b0;
    #1;
    check("fault_cleared", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; memReady = 1'b0;
    @(posedge clk); #1;                              // now in FETCH, stalled
    @(negedge clk);
    check("fetch_wait_memreq", {18'd0, outs}, {18'd0, P_F_WAIT});
    @(posedge clk); #3;
    rst_n = 1'b0;                                    // mid-cycle, mid-access
    #1;
    check("async_reset_memreq", {18'd0, outs}, {18'd0, P_IDLE});
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef LEGV8_SEQ_PERF_EN
    check("retired_after_reset", retired, 32'd0);
`endif

    // ADD, STUR, B back to back with no stalls: 1 + 4 + 4 + 2 cycles
    perf_ops = '{11'h000, 11'h458, 11'h458, 11'h458, 11'h458,
                 11'h7C0, 11'h7C0, 11'h7C0, 11'h7C0, 11'h0A0, 11'h0A0};
    n_pcw = 0; n_irw = 0; n_rw = 0; n_mwe = 0;
    memReady = 1'b1; aluZero = 1'b0;
    for (int c = 0; c < 11; c++) begin
      opcode = perf_ops[c];
      @(negedge clk);
      n_pcw += int'(pcWrite);
      n_irw += int'(irWrite);
      n_rw  += int'(regWrite);
      n_mwe += int'(memWriteEn);
      @(posedge clk); #1;
    end
    check("seq_pcwrite_pulses", n_pcw, 32'd4);
    check("seq_irwrite_pulses", n_irw, 32'd3);
    check("seq_regwrite_pulses", n_rw, 32'd1);
    check("seq_memwrite_cycles", n_mwe, 32'd1);
    @(negedge clk);
    check("seq_back_in_fetch", {18'd0, outs}, {18'd0, P_F_OK});
`ifdef LEGV8_SEQ_PERF_EN
    check("retired_after_three", retired, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_legv8_multicycle_sequencer
`default_nettype wire
